// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC rotator: arctangent table,
// inverse gain, FSM state and pre-rotation quadrant encodings.
package cordic_pkg;

  localparam int ATAN_N = 16;

  // round(atan(2^-i) * 2^15 / pi), binary angle with +2^15 == +pi
  localparam logic [15:0] ATAN [ATAN_N] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297,
    16'd651,  16'd326,  16'd163,  16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,
    16'd3,    16'd1,    16'd1,    16'd0
  };

  // 1/K(16) = 0.6072529 in Q1.20
  localparam int INV_GAIN = 636751;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREROT,
    S_ITER,
    S_OUT
  } state_e;

  typedef enum logic [1:0] {
    Q_0   = 2'b00,
    Q_90  = 2'b01,
    Q_180 = 2'b10,
    Q_270 = 2'b11
  } quad_e;

endpackage

// File: rtl/cordic_rot_round_sat.sv
// Round-half-up by FRAC bits, then saturate to a signed OUT_W result.
// Purely combinational; used once per output component.
module cordic_rot_round_sat #(
  parameter int IN_W  = 22,
  parameter int FRAC  = 4,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic [IN_W:0] RND = (IN_W+1)'(1) << (FRAC-1);

  logic signed [IN_W:0]      sum;
  logic signed [IN_W:0]      shr;
  logic [IN_W-OUT_W+1:0]     top;

  assign sum = {din[IN_W-1], din} + RND;
  assign shr = sum >>> FRAC;
  assign top = shr[IN_W:OUT_W-1];

  // in range when all bits above the result MSB agree with it
  always_comb begin
    if (&top || ~|top) begin
      dout = shr[OUT_W-1:0];
    end else if (shr[IN_W]) begin
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      dout = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/cordic_rot_iter.sv
// Iterative CORDIC rotation engine, one micro-rotation per clock.
// Define CORDIC_ROT_GAIN_COMP_EN to scale outputs by 1/K before rounding.
module cordic_rot_iter
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ANGLE_WIDTH   = 16,
  parameter int CORDIC_WIDTH  = 22,
  parameter int CORDIC_STAGES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cordic_rot_en,
  input  logic [DATA_WIDTH-1:0]    cordic_rot_xin,
  input  logic [DATA_WIDTH-1:0]    cordic_rot_yin,
  input  logic [ANGLE_WIDTH-1:0]   cordic_rot_angle_in,
  input  logic                     cordic_rot_angle_microRot_n,
  input  logic [CORDIC_STAGES-1:0] cordic_rot_microRot_ext_in,
  input  logic                     cordic_rot_microRot_ext_vld,
  input  logic [1:0]               cordic_rot_quad_in,
  output logic                     cordic_rot_opvld,
  output logic [DATA_WIDTH-1:0]    cordic_rot_xout,
  output logic [DATA_WIDTH-1:0]    cordic_rot_yout,
  output logic                     busy
);

  localparam int CW    = CORDIC_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int AW    = ANGLE_WIDTH;
  localparam int ZW    = ANGLE_WIDTH + 1;
  localparam int SH    = CW - DW - 2;
  localparam int CNT_W = (CORDIC_STAGES > 1) ? $clog2(CORDIC_STAGES) : 1;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [CW-1:0]      x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]      z_q, z_d;
  logic                      mode_q, mode_d;
  logic [CORDIC_STAGES-1:0]  ext_q, ext_d;
  quad_e                     quad_q, quad_d;
  logic                      opvld_q, opvld_d;
  logic [DW-1:0]             xout_q, xout_d;
  logic [DW-1:0]             yout_q, yout_d;

  logic                      accept;
  logic                      dir;
  logic signed [CW-1:0]      xs, ys;
  logic signed [ZW-1:0]      atan_z;
  logic signed [DW-1:0]      xr, yr;

  assign accept = (state_q == S_IDLE) && cordic_rot_en &&
                  (cordic_rot_angle_microRot_n ||
                   cordic_rot_microRot_ext_vld);

  assign dir    = mode_q ? ~z_q[ZW-1] : ext_q[cnt_q];
  assign xs     = y_q >>> cnt_q;
  assign ys     = x_q >>> cnt_q;
  assign atan_z = $signed(ZW'(ATAN[cnt_q]));

`ifdef CORDIC_ROT_GAIN_COMP_EN
  localparam int RW = 2 * CW;
  localparam int RF = SH + CW - 2;
  logic signed [RW-1:0] xr_in, yr_in;
  assign xr_in = RW'(x_q) * RW'(INV_GAIN);
  assign yr_in = RW'(y_q) * RW'(INV_GAIN);
`else
  localparam int RW = CW;
  localparam int RF = SH;
  logic signed [RW-1:0] xr_in, yr_in;
  assign xr_in = x_q;
  assign yr_in = y_q;
`endif

  cordic_rot_round_sat #(
    .IN_W (RW),
    .FRAC (RF),
    .OUT_W(DW)
  ) u_rs_x (
    .din (xr_in),
    .dout(xr)
  );

  cordic_rot_round_sat #(
    .IN_W (RW),
    .FRAC (RF),
    .OUT_W(DW)
  ) u_rs_y (
    .din (yr_in),
    .dout(yr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mode_d  = mode_q;
    ext_d   = ext_q;
    quad_d  = quad_q;
    opvld_d = 1'b0;
    xout_d  = xout_q;
    yout_d  = yout_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_PREROT;
          x_d     = $signed({{(CW-DW){cordic_rot_xin[DW-1]}},
                             cordic_rot_xin}) <<< SH;
          y_d     = $signed({{(CW-DW){cordic_rot_yin[DW-1]}},
                             cordic_rot_yin}) <<< SH;
          z_d     = {cordic_rot_angle_in[AW-1], cordic_rot_angle_in};
          mode_d  = cordic_rot_angle_microRot_n;
          ext_d   = cordic_rot_microRot_ext_in;
          quad_d  = quad_e'(cordic_rot_quad_in);
        end
      end
      S_PREROT: begin
        state_d = S_ITER;
        cnt_d   = '0;
        if (mode_q) begin
          // fold |theta| > pi/2 into the convergence range
          if (z_q[AW-1] ^ z_q[AW-2]) begin
            x_d = -x_q;
            y_d = -y_q;
            z_d = {~z_q[AW-1], ~z_q[AW-1], z_q[AW-2:0]};
          end
        end else begin
          unique case (quad_q)
            Q_0:   ;
            Q_90:  begin x_d = -y_q; y_d = x_q;  end
            Q_180: begin x_d = -x_q; y_d = -y_q; end
            Q_270: begin x_d = y_q;  y_d = -x_q; end
          endcase
        end
      end
      S_ITER: begin
        if (dir) begin
          x_d = x_q - xs;
          y_d = y_q + ys;
          z_d = z_q - atan_z;
        end else begin
          x_d = x_q + xs;
          y_d = y_q - ys;
          z_d = z_q + atan_z;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CORDIC_STAGES-1)) begin
          state_d = S_OUT;
          cnt_d   = '0;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
        opvld_d = 1'b1;
        xout_d  = xr;
        yout_d  = yr;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mode_q  <= 1'b0;
      ext_q   <= '0;
      quad_q  <= Q_0;
      opvld_q <= 1'b0;
      xout_q  <= '0;
      yout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mode_q  <= mode_d;
      ext_q   <= ext_d;
      quad_q  <= quad_d;
      opvld_q <= opvld_d;
      xout_q  <= xout_d;
      yout_q  <= yout_d;
    end
  end

  assign cordic_rot_opvld = opvld_q;
  assign cordic_rot_xout  = xout_q;
  assign cordic_rot_yout  = yout_q;
  assign busy             = (state_q != S_IDLE);

endmodule

// File: doc/cordic_rot_iter.md
# cordic_rot_iter

Iterative (one micro-rotation per clock) CORDIC rotation-mode engine. It sits on the responder side of the cordic_rot_* request/result interface that the GSO and other FastICA controllers drive. It accepts one rotation request at a time, either angle-driven or externally-directed, and returns the rotated vector with a one-cycle valid pulse. It is an area-lean alternative to the doubly-pipelined CORDIC top, sized for controllers that issue one request and wait for the result.

## Interface
- DATA_WIDTH, 16: signed I/O sample width.
- ANGLE_WIDTH, 16: signed binary angle; +2^(ANGLE_WIDTH-1) ≙ +π, so the value wraps modulo 2π.
- CORDIC_WIDTH, 22: internal x/y datapath width; must be ≥ DATA_WIDTH+2.
- CORDIC_STAGES, 16: number of micro-rotations; 1..ANGLE_WIDTH-1.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cordic_rot_en  in  1  request strobe, one cycle.
- cordic_rot_xin, cordic_rot_yin  in  DATA_WIDTH  signed input vector.
- cordic_rot_angle_in  in  ANGLE_WIDTH  rotation angle (angle mode).
- cordic_rot_angle_microRot_n  in  1  1 = angle mode; 0 = external-direction mode.
- cordic_rot_microRot_ext_in  in  CORDIC_STAGES  external directions; bit i = 1 means +atan(2^-i).
- cordic_rot_microRot_ext_vld  in  1  ext_in valid.
- cordic_rot_quad_in  in  2  pre-rotation by quad·π/2 (external-direction mode only).
- cordic_rot_opvld  out  1  result valid pulse.
- cordic_rot_xout, cordic_rot_yout  out  DATA_WIDTH  signed result; held until the next result.
- busy  out  1  high whenever the state is not S_IDLE.

## Operation
- States:
  - S_IDLE → S_PREROT when a request is accepted.
  - S_PREROT → S_ITER.
  - S_ITER loops CORDIC_STAGES times, counting 0..CORDIC_STAGES-1, → S_OUT.
  - S_OUT → S_IDLE.
- Accept rule: in S_IDLE with cordic_rot_en=1 and (microRot_n=1 or ext_vld=1). All inputs are captured at that edge.
- Ignored requests:
  - A request with microRot_n=0 and ext_vld=0 is ignored.
  - en is ignored in any state other than S_IDLE. There is no queue.
- Input load: x and y are sign-extended and shifted left by CORDIC_WIDTH-DATA_WIDTH-2, giving 2 guard MSBs and fractional LSBs.
- S_PREROT, angle mode: if angle[MSB] ≠ angle[MSB-1] (|θ| > π/2), negate x and y and invert angle MSB. Residual z = angle.
- S_PREROT, external-direction mode, by quad_in:
  - 00: (x,y)
  - 01: (-y,x)
  - 10: (-x,-y)
  - 11: (y,-x)
- S_ITER step i:
  - Direction d = +1 if z ≥ 0, else -1 (angle mode); d = ext_in[i] ? +1 : -1 (external mode).
  - x' = x - d·(y>>>i); y' = y + d·(x>>>i); z' = z - d·ATAN[i].
- S_OUT: optional gain compensation (see Configuration), then round-half-up to DATA_WIDTH, then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Register the outputs and pulse opvld.

## Timing
- Reset values: opvld=0, xout=0, yout=0, busy=0, state S_IDLE, iteration counter=0.
- Latency: the accepting edge is E0. opvld is driven high by edge E0+CORDIC_STAGES+2 and stays high for exactly one cycle. Latency is fixed and independent of mode and macro.
- The opvld cycle is already in S_IDLE, so en in that same cycle is accepted. Back-to-back throughput is one result per CORDIC_STAGES+2 cycles.
- xin/yin/angle/ext_in may change freely after E0.
- Reset mid-operation returns to S_IDLE immediately. No opvld is produced for the aborted request, and outputs clear to 0.
- Arithmetic wrap:
  - The internal x/y guard bits prevent overflow for any input.
  - z is ANGLE_WIDTH+1 bits wide, so there is no wrap during iteration.

## Configuration
- CORDIC_ROT_GAIN_COMP_EN defined: S_OUT multiplies x and y by 1/K(CORDIC_STAGES), using constant INV_GAIN (≈0.607253 in Q1.(CORDIC_WIDTH-2)), before rounding. Output magnitude equals input magnitude.
- CORDIC_ROT_GAIN_COMP_EN undefined: no multiplier. Outputs carry the CORDIC gain K≈1.64676, and the caller compensates.
- Latency is identical in both builds.

## Structure
- Shared package cordic_pkg holds:
  - ATAN table: CORDIC_STAGES entries, round(atan(2^-i)·2^(ANGLE_WIDTH-1)/π).
  - INV_GAIN constant.
  - State encoding.
  - Quadrant encoding.
- One natural sub-module: cordic_rot_round_sat, the combinational round-and-saturate function, reused on xout and yout.

## Test plan
Tolerances assume CORDIC_ROT_GAIN_COMP_EN is defined.
- Angle mode, xin=16384, yin=0, angle=16'h2000 (π/4) → xout=yout=11585±4. opvld arrives exactly 18 cycles after en.
- xin=10000, yin=0, angle=16'h4000 (π/2) → xout=0±4, yout=10000±4. With angle=16'h8000 (-π) → xout=-10000±4, yout=0±4.
- xin=yin=32767, angle=16'h2000 → yout saturates to 32767, xout=0±4.
- External mode, quad_in=01, ext_in = the directions the bit-true model generates for θ=π/4, with xin=16384, yin=0 → xout=-11585±4, yout=11585±4.
- en pulsed again 5 cycles after an accepted en → only one opvld, result of the first request. en held during the opvld cycle → accepted, second opvld 18 cycles later. en with microRot_n=0 and ext_vld=0 → no opvld, busy stays 0.
- rst_n asserted at cycle 8 of a request → opvld never asserts, xout=yout=0, busy=0. A new request after release completes normally.
